buzzer_sched: RTL

Scheduler that shares the single piezo/buzzer output between up to three sound requesters: alarm, power-on jingle and key-click. Each requester supplies a tone half-period and a duration. The block grants one requester at a time by fixed priority and generates the square wave itself. It signals completion per requester and enforces a silent gap between consecutive grants. It sits between the sound-producing FSMs and the top-level `melody` pin.

---
 rtl/buzz_pkg.sv | 16 +
 rtl/buzzer_sched_if.sv | 30 +++
 rtl/tone_gen.sv | 47 ++++
 rtl/buzzer_sched.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/buzz_pkg.sv
// Shared types and constants for the buzzer scheduler.
package buzz_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } buzz_state_e;

  // Requester slots; a lower index has higher priority.
  localparam int REQ_ALARM    = 0;
  localparam int REQ_POWERON  = 1;
  localparam int REQ_KEYCLICK = 2;

endpackage

// File: rtl/buzzer_sched_if.sv
// Request/grant bundle between the sound-producing FSMs and the buzzer scheduler.
//
// Handshake: req[i] is a level request. The requester raises it and holds it
// (with its half_period/duration slice) until the scheduler answers with a
// one-cycle done[i] or abort[i] pulse. gnt[i] is high while slot i owns the
// buzzer. Dropping req[i] while granted ends the grant early (abort[i]).
// A req[i] still high after done[i] is treated as a new request.
interface buzzer_sched_if #(
  parameter int NREQ = 3,
  parameter int W    = 32
) ();
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] half_period;
  logic [NREQ*W-1:0] duration;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   abort;
  logic              busy;
  logic              melody;

  modport master (
    output req, half_period, duration,
    input  gnt, done, abort, busy, melody
  );

  modport slave (
    input  req, half_period, duration,
    output gnt, done, abort, busy, melody
  );
endinterface

// File: rtl/tone_gen.sv
// Square-wave generator: toggles melody every half_period cycles while en is
// high. clear returns the counter and output to 0 (first PLAY cycle, idle, gap).
module tone_gen #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clear,
  input  logic [W-1:0] half_period,
  output logic         melody
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         mel_q, mel_d;

  // Next tone counter / toggle value; clear dominates en.
  always_comb begin
    cnt_d = cnt_q;
    mel_d = mel_q;
    if (clear) begin
      cnt_d = '0;
      mel_d = 1'b0;
    end else if (en) begin
      if (cnt_q == half_period - W'(1)) begin
        cnt_d = '0;
        mel_d = ~mel_q;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  // Tone state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      mel_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mel_q <= mel_d;
    end
  end

  assign melody = mel_q;

endmodule

// File: rtl/buzzer_sched.sv
// Buzzer scheduler: fixed-priority arbitration of up to NREQ sound requesters
// onto one piezo output, with per-grant duration, done/abort pulses and a
// silent gap between grants.
// Optional macro BUZZ_PREEMPT_EN: a higher-priority request ends the current
// grant immediately (abort) and takes the buzzer without a gap.
module buzzer_sched
  import buzz_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int W    = 32,
  parameter int GAP  = 1_000_000
) (
  input  logic           clk,
  input  logic           rst,
  buzzer_sched_if.slave  bus,
  output buzz_state_e    dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  buzz_state_e     state_q, state_d;
  logic [IW-1:0]   win_q, win_d;
  logic [W-1:0]    hp_q, hp_d;
  logic [W-1:0]    dur_q, dur_d;
  logic [W-1:0]    gap_q, gap_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] abort_q, abort_d;
  logic            busy_q, busy_d;

  logic [IW-1:0]   pick;
  logic            req_any;
  logic            own_req;
  logic            tone_run;
  logic            finish;
  logic            melody_w;

  // A zero field would never terminate the count; treat it as one cycle.
  function automatic logic [W-1:0] nz(input logic [W-1:0] v);
    return (v == '0) ? W'(1) : v;
  endfunction

  // Lowest-index set request wins the arbitration.
  always_comb begin
    pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) pick = IW'(i);
    end
  end

  assign req_any = |bus.req;
  assign own_req = |(bus.req & (ONE << win_q));

  // FSM next state, latched fields, counters and registered outputs.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    hp_d     = hp_q;
    dur_d    = dur_q;
    gap_d    = gap_q;
    done_d   = '0;
    abort_d  = '0;
    tone_run = 1'b0;
    finish   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          state_d = ST_PLAY;
          win_d   = pick;
          hp_d    = nz(bus.half_period[int'(pick)*W +: W]);
          dur_d   = nz(bus.duration[int'(pick)*W +: W]);
        end
      end
      ST_PLAY: begin
        if (dur_q == W'(1)) begin
          // Completion wins over a same-cycle release or preemption.
          done_d = ONE << win_q;
          finish = 1'b1;
        end
`ifdef BUZZ_PREEMPT_EN
        else if (req_any && (pick < win_q)) begin
          abort_d = ONE << win_q;
          win_d   = pick;
          hp_d    = nz(bus.half_period[int'(pick)*W +: W]);
          dur_d   = nz(bus.duration[int'(pick)*W +: W]);
        end
`endif
        else if (!own_req) begin
          abort_d = ONE << win_q;
          finish  = 1'b1;
        end else begin
          dur_d    = dur_q - W'(1);
          tone_run = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q <= W'(1)) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      dur_d = '0;
      if (GAP == 0) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_GAP;
        gap_d   = W'(GAP);
      end
    end

    gnt_d  = (state_d == ST_PLAY) ? (ONE << win_d) : '0;
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      hp_q    <= '0;
      dur_q   <= '0;
      gap_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      abort_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      hp_q    <= hp_d;
      dur_q   <= dur_d;
      gap_q   <= gap_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
    end
  end

  tone_gen #(.W(W)) u_tone (
    .clk         (clk),
    .rst         (rst),
    .en          (state_q == ST_PLAY),
    .clear       (!tone_run),
    .half_period (hp_q),
    .melody      (melody_w)
  );

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.abort  = abort_q;
  assign bus.busy   = busy_q;
  assign bus.melody = melody_w;
  assign dbg_state  = state_q;

endmodule
